// File: rtl/light_monitor.sv
// Safety monitor for the traffic light interface.
// Latches the first rule violation as a sticky fault code.
module light_monitor #(
  parameter int unsigned CNT_W = 32,
  parameter logic [CNT_W-1:0] MIN_YELLOW = 100000000,
  parameter logic [CNT_W-1:0] ALL_RED_MIN = 50000000,
  parameter logic [CNT_W-1:0] MAX_DWELL = 1300000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] Light1,
  input  logic [2:0] Light2,
  input  logic       TurnLight,
  input  logic       Emergency,
  input  logic       PowerOutage,
  input  logic       ClearFault,
  output logic       Fault,
  output logic [2:0] FaultCode,
  output logic [7:0] FaultCount
);

  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;
  localparam logic [2:0] OFF = 3'b000;

  logic [2:0]       l1q, l2q;
  logic             tlq, prev_valid;
  logic [CNT_W-1:0] yel1, yel2, allred, stable;
  logic [2:0]       code_n;
  logic             chg1, chg2, chg_any, wd;
  logic             both_red;

  function automatic logic bad_enc(input logic [2:0] l);
    return !(l inside {RED, YEL, GRN, OFF});
  endfunction

  function automatic logic legal(
    input logic [2:0] p,
    input logic [2:0] c,
    input logic       em
  );
    logic ok;
    ok = (p == GRN && c == YEL) ||
         (p == YEL && c == RED) ||
         (p == RED && c == GRN);
    if (p == GRN && c == RED && em) ok = 1'b1;
    if ((p == OFF || c == OFF) && em) ok = 1'b1;
    return ok;
  endfunction

  function automatic logic [CNT_W-1:0] sat(
    input logic [CNT_W-1:0] v
  );
    return (&v) ? v : v + 1'b1;
  endfunction

  always_comb begin
    code_n   = 3'd0;
    chg1     = prev_valid && (Light1 != l1q);
    chg2     = prev_valid && (Light2 != l2q);
    chg_any  = (Light1 != l1q) || (Light2 != l2q) ||
               (TurnLight != tlq);
    wd       = !PowerOutage && (stable >= MAX_DWELL);
    both_red = (Light1 == RED) && (Light2 == RED);
    if (bad_enc(Light1) || bad_enc(Light2))
      code_n = 3'd1;
    else if (!PowerOutage && Light1 != RED &&
             Light2 != RED)
      code_n = 3'd2;
    else if (!PowerOutage &&
             ((chg1 && !legal(l1q, Light1, Emergency)) ||
              (chg2 && !legal(l2q, Light2, Emergency))))
      code_n = 3'd3;
    else if (!PowerOutage &&
             ((chg1 && l1q == YEL && Light1 == RED &&
               yel1 < MIN_YELLOW) ||
              (chg2 && l2q == YEL && Light2 == RED &&
               yel2 < MIN_YELLOW)))
      code_n = 3'd4;
    else if (!PowerOutage && allred < ALL_RED_MIN &&
             ((chg1 && l1q == RED && Light1 == GRN) ||
              (chg2 && l2q == RED && Light2 == GRN)))
      code_n = 3'd5;
    else if (TurnLight && (Light1 != RED || Light2 != RED))
      code_n = 3'd6;
    else if (wd)
      code_n = 3'd7;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      l1q        <= OFF;
      l2q        <= OFF;
      tlq        <= 1'b0;
      prev_valid <= 1'b0;
      yel1       <= '0;
      yel2       <= '0;
      allred     <= '0;
      stable     <= '0;
      Fault      <= 1'b0;
      FaultCode  <= 3'd0;
      FaultCount <= 8'd0;
    end else begin
      l1q        <= Light1;
      l2q        <= Light2;
      tlq        <= TurnLight;
      prev_valid <= 1'b1;
      // Entry cycle counts as the first yellow cycle.
      yel1 <= (Light1 != YEL) ? '0 :
              (l1q == YEL) ? sat(yel1) : CNT_W'(1);
      yel2 <= (Light2 != YEL) ? '0 :
              (l2q == YEL) ? sat(yel2) : CNT_W'(1);
      allred <= both_red ? sat(allred) : '0;
      stable <= (chg_any || PowerOutage || wd) ?
                '0 : sat(stable);
      if (code_n != 3'd0) begin
        Fault <= 1'b1;
        if (!Fault || ClearFault) FaultCode <= code_n;
        if (FaultCount != 8'hff)
          FaultCount <= FaultCount + 8'd1;
      end else if (ClearFault) begin
        Fault     <= 1'b0;
        FaultCode <= 3'd0;
      end
    end
  end

endmodule
